// File: rtl/run_sequencer_pkg.sv
// Shared types and constants for the run sequencer.
// State encodings are visible on the state output, so values are fixed.
package run_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_IMEM = 3'd1,
    LOAD_DMEM = 3'd2,
    EXECUTE   = 3'd3,
    UNLOAD    = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } state_e;

  // Meaning of each captured descriptor slot.
  localparam int Q_END   = 0;
  localparam int R_START = 1;
  localparam int R_END   = 2;

endpackage

// File: rtl/run_sequencer_cycle_counter.sv
// Saturating cycle counter with synchronous clear and count enable.
// Clear has priority over enable. The value holds at all-ones instead of wrapping.
module run_cycle_counter #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear, then increment unless saturated.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/run_sequencer.sv
// Load/execute/unload controller for the multi-core processor top.
// It sequences the instruction load, data load, execution and unload phases.
// It arbitrates the data-memory port between the UART side and the processor.
// It captures descriptor words during the data load and times execution.
// Optional build macro RUN_SEQUENCER_WATCHDOG_EN adds an execution watchdog
// that moves the controller to ERROR after WDOG_CYCLES cycles without proc_done.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int CORE_COUNT      = 2,
  parameter int REG_WIDTH       = 12,
  parameter int DMEM_WIDTH      = CORE_COUNT * REG_WIDTH,
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int NUM_DESC        = 3,
  parameter int DESC_ADDR_BASE  = 5,
  parameter int CYC_WIDTH       = 26,
  parameter int WDOG_CYCLES     = 2 ** 24
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic                          start,
  input  logic                          skip_imem,
  input  logic                          rerun,
  input  logic                          imem_rx_done,
  input  logic                          dmem_rx_done,
  input  logic                          proc_done,
  input  logic                          dmem_tx_done,
  input  logic                          proc_ready,
  input  logic                          uart_dmem_wr_en,
  input  logic [DMEM_ADDR_WIDTH-1:0]    uart_dmem_addr,
  input  logic [DMEM_WIDTH-1:0]         uart_dmem_data,
  input  logic                          proc_dmem_wr_en,
  input  logic [DMEM_ADDR_WIDTH-1:0]    proc_dmem_addr,
  input  logic [DMEM_WIDTH-1:0]         proc_dmem_data,
  output logic                          dmem_wr_en,
  output logic [DMEM_ADDR_WIDTH-1:0]    dmem_addr,
  output logic [DMEM_WIDTH-1:0]         dmem_data,
  output logic                          imem_rx_en,
  output logic                          dmem_rx_en,
  output logic                          proc_start,
  output logic                          dmem_tx_start,
  output logic [NUM_DESC*REG_WIDTH-1:0] desc,
  output logic [CYC_WIDTH-1:0]          run_cycles,
  output logic [2:0]                    state,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  state_e state_q, state_d;
  logic   proc_start_q, proc_start_d;
  logic   dmem_tx_start_q, dmem_tx_start_d;
  logic [NUM_DESC*REG_WIDTH-1:0] desc_q, desc_d;
  logic   exec_entry;
  logic   in_execute;
  logic   wdog_hit;
  state_e full_run_target;

  assign full_run_target = skip_imem ? LOAD_DMEM : LOAD_IMEM;
  assign in_execute      = (state_q == EXECUTE);

`ifdef RUN_SEQUENCER_WATCHDOG_EN
  localparam int WDOG_WIDTH = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_WIDTH-1:0] wdog_count;

  run_cycle_counter #(
    .WIDTH(WDOG_WIDTH)
  ) u_wdog_counter (
    .clk   (clk),
    .rstN  (rstN),
    .clear (exec_entry),
    .enable(in_execute),
    .count (wdog_count)
  );

  // The limit is hit in the last allowed EXECUTE cycle, so the move to ERROR happens after exactly WDOG_CYCLES cycles.
  assign wdog_hit = in_execute && (wdog_count == WDOG_WIDTH'(WDOG_CYCLES - 1));
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_CYCLES;
  assign wdog_hit        = 1'b0;
`endif

  // Next state: advance on phase-completion pulses, ignore pulses elsewhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = full_run_target;
      end
      LOAD_IMEM: begin
        if (imem_rx_done) state_d = LOAD_DMEM;
      end
      LOAD_DMEM: begin
        if (dmem_rx_done && proc_ready) state_d = EXECUTE;
      end
      EXECUTE: begin
        if (proc_done) begin
          state_d = UNLOAD;
        end else if (wdog_hit) begin
          state_d = ERROR;
        end
      end
      UNLOAD: begin
        if (dmem_tx_done) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = full_run_target;
        end else if (rerun && proc_ready) begin
          state_d = EXECUTE;
        end
      end
      ERROR: begin
        if (start) state_d = full_run_target;
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry pulses for the processor start and the unload start.
  always_comb begin
    exec_entry      = (state_d == EXECUTE) && (state_q != EXECUTE);
    proc_start_d    = exec_entry;
    dmem_tx_start_d = (state_d == UNLOAD) && (state_q != UNLOAD);
  end

  // Descriptor table: cleared on entering LOAD_DMEM, loaded by matching UART writes.
  always_comb begin
    desc_d = desc_q;
    if ((state_d == LOAD_DMEM) && (state_q != LOAD_DMEM)) begin
      desc_d = '0;
    end else if ((state_q == LOAD_DMEM) && uart_dmem_wr_en) begin
      for (int i = 0; i < NUM_DESC; i++) begin
        if (uart_dmem_addr == DMEM_ADDR_WIDTH'(DESC_ADDR_BASE + i)) begin
          desc_d[i*REG_WIDTH +: REG_WIDTH] = uart_dmem_data[REG_WIDTH-1:0];
        end
      end
    end
  end

  // Control and descriptor registers.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q         <= IDLE;
      proc_start_q    <= 1'b0;
      dmem_tx_start_q <= 1'b0;
      desc_q          <= '0;
    end else begin
      state_q         <= state_d;
      proc_start_q    <= proc_start_d;
      dmem_tx_start_q <= dmem_tx_start_d;
      desc_q          <= desc_d;
    end
  end

  // Execution timer: zero in the first EXECUTE cycle, then counts each EXECUTE cycle.
  run_cycle_counter #(
    .WIDTH(CYC_WIDTH)
  ) u_run_counter (
    .clk   (clk),
    .rstN  (rstN),
    .clear (exec_entry),
    .enable(in_execute),
    .count (run_cycles)
  );

  // Data-memory port owner is chosen by phase; unload only reads, so writes are blocked.
  always_comb begin
    dmem_wr_en = 1'b0;
    dmem_addr  = '0;
    dmem_data  = '0;
    case (state_q)
      LOAD_DMEM: begin
        dmem_wr_en = uart_dmem_wr_en;
        dmem_addr  = uart_dmem_addr;
        dmem_data  = uart_dmem_data;
      end
      UNLOAD: begin
        dmem_addr  = uart_dmem_addr;
        dmem_data  = uart_dmem_data;
      end
      EXECUTE: begin
        dmem_wr_en = proc_dmem_wr_en;
        dmem_addr  = proc_dmem_addr;
        dmem_data  = proc_dmem_data;
      end
      default: begin
      end
    endcase
  end

  // Status and receive gates decoded from the current state.
  always_comb begin
    imem_rx_en = (state_q == LOAD_IMEM);
    dmem_rx_en = (state_q == LOAD_DMEM);
    busy       = (state_q == LOAD_IMEM) || (state_q == LOAD_DMEM) ||
                 (state_q == EXECUTE)   || (state_q == UNLOAD);
    done       = (state_q == DONE);
`ifdef RUN_SEQUENCER_WATCHDOG_EN
    error      = (state_q == ERROR);
`else
    error      = 1'b0;
`endif
  end

  assign proc_start    = proc_start_q;
  assign dmem_tx_start = dmem_tx_start_q;
  assign desc          = desc_q;
  assign state         = state_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed testbench for run_sequencer.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
module tb_run_sequencer;
  import run_sequencer_pkg::*;

`ifdef RUN_SEQUENCER_WATCHDOG_EN
  localparam int EXEC_LEN = 40;
`else
  localparam int EXEC_LEN = 100;
`endif
  localparam int WDOG = 50;
  localparam logic [35:0] DESC_EXP = {12'h020, 12'h0AB, 12'h010};

  logic        clk;
  logic        rstN;
  logic        start, skip_imem, rerun;
  logic        imem_rx_done, dmem_rx_done, proc_done, dmem_tx_done, proc_ready;
  logic        uart_dmem_wr_en, proc_dmem_wr_en;
  logic [11:0] uart_dmem_addr, proc_dmem_addr;
  logic [23:0] uart_dmem_data, proc_dmem_data;
  logic        dmem_wr_en;
  logic [11:0] dmem_addr;
  logic [23:0] dmem_data;
  logic        imem_rx_en, dmem_rx_en, proc_start, dmem_tx_start;
  logic [35:0] desc;
  logic [25:0] run_cycles;
  logic [2:0]  state;
  logic        busy, done, error;

  int vectors;
  int miscompares;

  run_sequencer #(
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk            (clk),
    .rstN           (rstN),
    .start          (start),
    .skip_imem      (skip_imem),
    .rerun          (rerun),
    .imem_rx_done   (imem_rx_done),
    .dmem_rx_done   (dmem_rx_done),
    .proc_done      (proc_done),
    .dmem_tx_done   (dmem_tx_done),
    .proc_ready     (proc_ready),
    .uart_dmem_wr_en(uart_dmem_wr_en),
    .uart_dmem_addr (uart_dmem_addr),
    .uart_dmem_data (uart_dmem_data),
    .proc_dmem_wr_en(proc_dmem_wr_en),
    .proc_dmem_addr (proc_dmem_addr),
    .proc_dmem_data (proc_dmem_data),
    .dmem_wr_en     (dmem_wr_en),
    .dmem_addr      (dmem_addr),
    .dmem_data      (dmem_data),
    .imem_rx_en     (imem_rx_en),
    .dmem_rx_en     (dmem_rx_en),
    .proc_start     (proc_start),
    .dmem_tx_start  (dmem_tx_start),
    .desc           (desc),
    .run_cycles     (run_cycles),
    .state          (state),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  // 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    tick();
    tick();
    rstN = 1'b1;
    vectors++; if (state !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    vectors++; if ({busy, done, error} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_status: got %b expected 000", {busy, done, error}); end
    vectors++; if ({imem_rx_en, dmem_rx_en, proc_start, dmem_tx_start} !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_pulses: got %b expected 0000", {imem_rx_en, dmem_rx_en, proc_start, dmem_tx_start}); end
    vectors++; if (desc !== 36'h0 || run_cycles !== 26'd0) begin miscompares++; $display("[TB] FAIL reset_regs: got desc %h cycles %0d expected 0 0", desc, run_cycles); end
    vectors++; if ({dmem_wr_en, dmem_addr, dmem_data} !== 37'h0) begin miscompares++; $display("[TB] FAIL reset_dmem: got %b %h %h expected zero", dmem_wr_en, dmem_addr, dmem_data); end
  endtask

  task automatic test_load_imem();
    skip_imem = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (state !== 3'd1 || imem_rx_en !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL load_imem: got state %0d imem_rx_en %b busy %b expected 1 1 1", state, imem_rx_en, busy); end
    imem_rx_done = 1'b1;
    tick();
    imem_rx_done = 1'b0;
    vectors++; if (state !== 3'd2 || dmem_rx_en !== 1'b1 || imem_rx_en !== 1'b0) begin miscompares++; $display("[TB] FAIL load_dmem: got state %0d dmem_rx_en %b imem_rx_en %b expected 2 1 0", state, dmem_rx_en, imem_rx_en); end
  endtask

  task automatic test_descriptors();
    logic [11:0] addrs [5];
    logic [23:0] datas [5];
    addrs = '{12'd5, 12'd7, 12'd8, 12'd6, 12'd4};
    datas = '{24'hABC010, 24'h555020, 24'h777030, 24'h9990AB, 24'h000FFF};
    for (int i = 0; i < 5; i++) begin
      uart_dmem_wr_en = 1'b1;
      uart_dmem_addr  = addrs[i];
      uart_dmem_data  = datas[i];
      #1;
      vectors++; if (dmem_wr_en !== 1'b1 || dmem_addr !== addrs[i] || dmem_data !== datas[i]) begin miscompares++; $display("[TB] FAIL load_passthru: got %b %h %h expected 1 %h %h", dmem_wr_en, dmem_addr, dmem_data, addrs[i], datas[i]); end
      tick();
    end
    uart_dmem_wr_en = 1'b0;
    vectors++; if (desc !== DESC_EXP) begin miscompares++; $display("[TB] FAIL desc_capture: got %h expected %h", desc, DESC_EXP); end
    vectors++; if (desc[Q_END*12 +: 12] !== 12'h010 || desc[R_START*12 +: 12] !== 12'h0AB || desc[R_END*12 +: 12] !== 12'h020) begin miscompares++; $display("[TB] FAIL desc_slots: got %h expected 020 0AB 010", desc); end
    dmem_rx_done = 1'b1;
    proc_ready   = 1'b0;
    tick();
    vectors++; if (state !== 3'd2) begin miscompares++; $display("[TB] FAIL wait_proc_ready: got %0d expected 2", state); end
    proc_ready = 1'b1;
    tick();
    dmem_rx_done = 1'b0;
  endtask

  task automatic test_execute();
    int ps_seen;
    vectors++; if (state !== 3'd3 || proc_start !== 1'b1 || run_cycles !== 26'd0) begin miscompares++; $display("[TB] FAIL exec_entry: got state %0d proc_start %b cycles %0d expected 3 1 0", state, proc_start, run_cycles); end
    proc_dmem_wr_en = 1'b1;
    proc_dmem_addr  = 12'h123;
    proc_dmem_data  = 24'h456789;
    uart_dmem_wr_en = 1'b1;
    uart_dmem_addr  = 12'd6;
    uart_dmem_data  = 24'h000FFF;
    #1;
    vectors++; if (dmem_wr_en !== 1'b1 || dmem_addr !== 12'h123 || dmem_data !== 24'h456789) begin miscompares++; $display("[TB] FAIL exec_arb: got %b %h %h expected 1 123 456789", dmem_wr_en, dmem_addr, dmem_data); end
    ps_seen = 1;
    for (int k = 2; k <= EXEC_LEN; k++) begin
      tick();
      ps_seen += int'(proc_start);
    end
    vectors++; if (ps_seen !== 1) begin miscompares++; $display("[TB] FAIL proc_start_width: got %0d cycles expected 1", ps_seen); end
    vectors++; if (state !== 3'd3 || run_cycles !== 26'(EXEC_LEN - 1)) begin miscompares++; $display("[TB] FAIL exec_last: got state %0d cycles %0d expected 3 %0d", state, run_cycles, EXEC_LEN - 1); end
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
  endtask

  task automatic test_unload();
    vectors++; if (state !== 3'd4 || dmem_tx_start !== 1'b1 || run_cycles !== 26'(EXEC_LEN)) begin miscompares++; $display("[TB] FAIL unload_entry: got state %0d tx_start %b cycles %0d expected 4 1 %0d", state, dmem_tx_start, run_cycles, EXEC_LEN); end
    uart_dmem_wr_en = 1'b1;
    uart_dmem_addr  = 12'h044;
    uart_dmem_data  = 24'h00ABCD;
    #1;
    vectors++; if (dmem_wr_en !== 1'b0 || dmem_addr !== 12'h044 || dmem_data !== 24'h00ABCD) begin miscompares++; $display("[TB] FAIL unload_arb: got %b %h %h expected 0 044 00ABCD", dmem_wr_en, dmem_addr, dmem_data); end
    tick();
    vectors++; if (dmem_tx_start !== 1'b0 || run_cycles !== 26'(EXEC_LEN)) begin miscompares++; $display("[TB] FAIL tx_start_width: got %b cycles %0d expected 0 %0d", dmem_tx_start, run_cycles, EXEC_LEN); end
    uart_dmem_wr_en = 1'b0;
    proc_dmem_wr_en = 1'b0;
    dmem_tx_done = 1'b1;
    tick();
    dmem_tx_done = 1'b0;
    vectors++; if (state !== 3'd5 || done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL done_state: got state %0d done %b busy %b expected 5 1 0", state, done, busy); end
    vectors++; if (desc !== DESC_EXP) begin miscompares++; $display("[TB] FAIL desc_hold: got %h expected %h", desc, DESC_EXP); end
    proc_done = 1'b1; imem_rx_done = 1'b1; dmem_rx_done = 1'b1;
    tick();
    proc_done = 1'b0; imem_rx_done = 1'b0; dmem_rx_done = 1'b0;
    vectors++; if (state !== 3'd5) begin miscompares++; $display("[TB] FAIL stray_pulses: got %0d expected 5", state); end
  endtask

  task automatic test_rerun();
    rerun = 1'b1;
    proc_ready = 1'b0;
    tick();
    vectors++; if (state !== 3'd5) begin miscompares++; $display("[TB] FAIL rerun_not_ready: got %0d expected 5", state); end
    proc_ready = 1'b1;
    tick();
    rerun = 1'b0;
    vectors++; if (state !== 3'd3 || proc_start !== 1'b1 || run_cycles !== 26'd0) begin miscompares++; $display("[TB] FAIL rerun_entry: got state %0d proc_start %b cycles %0d expected 3 1 0", state, proc_start, run_cycles); end
    vectors++; if (desc !== DESC_EXP) begin miscompares++; $display("[TB] FAIL rerun_desc: got %h expected %h", desc, DESC_EXP); end
    for (int k = 2; k <= 20; k++) tick();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    vectors++; if (state !== 3'd4 || run_cycles !== 26'd20) begin miscompares++; $display("[TB] FAIL rerun_cycles: got state %0d cycles %0d expected 4 20", state, run_cycles); end
    dmem_tx_done = 1'b1;
    tick();
    dmem_tx_done = 1'b0;
  endtask

  task automatic test_start_over_rerun();
    start = 1'b1; rerun = 1'b1; skip_imem = 1'b0;
    tick();
    start = 1'b0; rerun = 1'b0;
    vectors++; if (state !== 3'd1) begin miscompares++; $display("[TB] FAIL start_wins: got %0d expected 1", state); end
    imem_rx_done = 1'b1;
    tick();
    imem_rx_done = 1'b0;
    vectors++; if (state !== 3'd2 || desc !== 36'h0) begin miscompares++; $display("[TB] FAIL desc_clear: got state %0d desc %h expected 2 0", state, desc); end
    dmem_rx_done = 1'b1;
    tick();
    dmem_rx_done = 1'b0;
  endtask

  task automatic test_reset_mid_execute();
    for (int k = 0; k < 5; k++) tick();
    vectors++; if (state !== 3'd3 || run_cycles !== 26'd5) begin miscompares++; $display("[TB] FAIL pre_reset: got state %0d cycles %0d expected 3 5", state, run_cycles); end
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    proc_dmem_wr_en = 1'b1;
    proc_dmem_addr  = 12'h123;
    #1;
    vectors++; if (state !== 3'd0 || busy !== 1'b0 || run_cycles !== 26'd0 || desc !== 36'h0) begin miscompares++; $display("[TB] FAIL mid_reset: got state %0d busy %b cycles %0d desc %h expected 0 0 0 0", state, busy, run_cycles, desc); end
    vectors++; if ({dmem_wr_en, dmem_addr, proc_start, dmem_tx_start} !== 15'h0) begin miscompares++; $display("[TB] FAIL mid_reset_outs: got %b %h %b %b expected zero", dmem_wr_en, dmem_addr, proc_start, dmem_tx_start); end
    proc_dmem_wr_en = 1'b0;
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    vectors++; if (state !== 3'd0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL late_proc_done: got state %0d done %b expected 0 0", state, done); end
    skip_imem = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0; skip_imem = 1'b0;
    vectors++; if (state !== 3'd2) begin miscompares++; $display("[TB] FAIL skip_imem: got %0d expected 2", state); end
    dmem_rx_done = 1'b1;
    tick();
    dmem_rx_done = 1'b0;
  endtask

`ifdef RUN_SEQUENCER_WATCHDOG_EN
  task automatic test_watchdog();
    for (int k = 2; k <= WDOG; k++) tick();
    vectors++; if (state !== 3'd3 || error !== 1'b0) begin miscompares++; $display("[TB] FAIL wdog_before: got state %0d error %b expected 3 0", state, error); end
    tick();
    vectors++; if (state !== 3'd6 || error !== 1'b1 || busy !== 1'b0 || run_cycles !== 26'(WDOG)) begin miscompares++; $display("[TB] FAIL wdog_trip: got state %0d error %b busy %b cycles %0d expected 6 1 0 %0d", state, error, busy, run_cycles, WDOG); end
    rerun = 1'b1;
    tick();
    rerun = 1'b0;
    vectors++; if (state !== 3'd6 || run_cycles !== 26'(WDOG)) begin miscompares++; $display("[TB] FAIL error_hold: got state %0d cycles %0d expected 6 %0d", state, run_cycles, WDOG); end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (state !== 3'd1 || error !== 1'b0) begin miscompares++; $display("[TB] FAIL error_recover: got state %0d error %b expected 1 0", state, error); end
    imem_rx_done = 1'b1; tick(); imem_rx_done = 1'b0;
    dmem_rx_done = 1'b1; tick(); dmem_rx_done = 1'b0;
    for (int k = 2; k <= WDOG; k++) tick();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    vectors++; if (state !== 3'd4 || error !== 1'b0) begin miscompares++; $display("[TB] FAIL done_at_limit: got state %0d error %b expected 4 0", state, error); end
  endtask
`else
  task automatic test_watchdog();
    for (int k = 2; k <= WDOG + 10; k++) tick();
    vectors++; if (state !== 3'd3 || error !== 1'b0) begin miscompares++; $display("[TB] FAIL no_wdog: got state %0d error %b expected 3 0", state, error); end
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    vectors++; if (state !== 3'd4 || run_cycles !== 26'(WDOG + 10)) begin miscompares++; $display("[TB] FAIL no_wdog_cycles: got state %0d cycles %0d expected 4 %0d", state, run_cycles, WDOG + 10); end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rstN = 1'b0;
    start = 1'b0; skip_imem = 1'b0; rerun = 1'b0;
    imem_rx_done = 1'b0; dmem_rx_done = 1'b0; proc_done = 1'b0; dmem_tx_done = 1'b0;
    proc_ready = 1'b1;
    uart_dmem_wr_en = 1'b0; uart_dmem_addr = '0; uart_dmem_data = '0;
    proc_dmem_wr_en = 1'b0; proc_dmem_addr = '0; proc_dmem_data = '0;
    test_reset();
    test_load_imem();
    test_descriptors();
    test_execute();
    test_unload();
    test_rerun();
    test_start_over_rerun();
    test_reset_mid_execute();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
